// File: rtl/alu_issue_checker_pkg.sv
// Shared ALU instruction-interface types and the golden result function.
// Imported by the ALU variants, by alu_issue_checker and by ALU benches, so
// everybody agrees on the encoding and on the expected result of each opcode.
package alu_issue_checker_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    NOP = 2'd3
  } opcode_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [31:0] a;
    logic [31:0] b;
  } instruction_t;

  // Width of the ALU latency down-counter (latency 1..15).
  localparam int LAT_W = 4;

  // Expected ALU result, all arithmetic modulo 2^32. NOP has no defined
  // result; zero is returned and callers must not check it.
  function automatic logic [31:0] alu_expected(input instruction_t inst);
    logic [31:0] res;
    case (inst.opcode)
      ADD:     res = inst.a + inst.b;
      SUB:     res = inst.a - inst.b;
      MUL:     res = inst.a * inst.b;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // True for opcodes whose result is scored.
  function automatic logic alu_is_checked(input opcode_t op);
    return (op != NOP);
  endfunction

endpackage

// File: rtl/alu_issue_checker_ref_model.sv
// alu_ref_model: combinational reference for one ALU instruction.
// Ports:
//   inst_i      instruction currently presented to the ALU
//   expected_o  golden result for inst_i
//   check_en_o  1 when the result of inst_i is to be scored (not a NOP)
module alu_ref_model
  import alu_issue_checker_pkg::*;
(
  input  instruction_t inst_i,
  output logic [31:0]  expected_o,
  output logic         check_en_o
);

  assign expected_o = alu_expected(inst_i);
  assign check_en_o = alu_is_checked(inst_i.opcode);

endmodule

// File: rtl/alu_issue_checker.sv
// alu_issue_checker: replays a small program of ALU instructions into a
// clocked ALU and scores every returned result against alu_ref_model.
// Ports:
//   clock, reset_n          clock and async active-low reset
//   clear                   sync: empty buffer, zero stats, back to IDLE
//   load_valid/inst/ready   program load handshake (IDLE only)
//   start                   replay the loaded program from entry 0
//   IW                      registered instruction driven into the ALU
//   result                  ALU result, sampled ALU_LATENCY edges after IW
//   busy, done              replay in progress / replay finished (level)
//   pass_count, fail_count  scored entries of the last replay
//   fail_seen, first_fail_idx  first mismatch flag and its buffer index
//
// state  | meaning
// IDLE   | accepting program entries, waiting for start
// ISSUE  | IW just loaded with buf[rd_ptr]
// WAIT   | holding IW for ALU_LATENCY cycles
// CHECK  | result valid, scored on the edge leaving this state
// DONE   | replay finished, IW holds the last instruction
module alu_issue_checker
  import alu_issue_checker_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int ALU_LATENCY = 1,
  localparam int CW  = $clog2(DEPTH + 1),
  localparam int IW_ = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           clear,
  input  logic           load_valid,
  input  instruction_t   load_inst,
  output logic           load_ready,
  input  logic           start,
  output instruction_t   IW,
  input  logic [31:0]    result,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  pass_count,
  output logic [CW-1:0]  fail_count,
  output logic           fail_seen,
  output logic [IW_-1:0] first_fail_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state_q;
  instruction_t    iw_q;
  instruction_t    buf_q [DEPTH];
  logic [CW-1:0]   count_q;
  logic [IW_-1:0]  rd_ptr_q;
  logic [LAT_W-1:0] wait_cnt_q;
  logic [CW-1:0]   pass_q;
  logic [CW-1:0]   fail_q;
  logic            fail_seen_q;
  logic [IW_-1:0]  first_fail_q;
  logic            busy_q;
  logic            done_q;

  logic [31:0]     expected;
  logic            check_en;
  logic            mismatch;
  logic            last_entry;
  logic            load_fire;
  logic [IW_-1:0]  next_idx;
  logic [IW_-1:0]  wr_idx;

  alu_ref_model u_ref (
    .inst_i     (iw_q),
    .expected_o (expected),
    .check_en_o (check_en)
  );

  assign load_ready = (state_q == S_IDLE) && (count_q < CW'(DEPTH));
  // clear wins over a simultaneous load.
  assign load_fire  = load_valid && load_ready && !clear;
  // Entries are only appended, so the fill level is also the write pointer.
  assign wr_idx     = count_q[IW_-1:0];
  assign next_idx   = rd_ptr_q + IW_'(1);
  assign last_entry = (CW'(rd_ptr_q) == (count_q - CW'(1)));
  assign mismatch   = (result != expected);

  // Program storage: contents are don't-care until loaded, so no reset.
  always_ff @(posedge clock) begin
    if (load_fire) begin
      buf_q[wr_idx] <= load_inst;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      iw_q         <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wait_cnt_q   <= '0;
      pass_q       <= '0;
      fail_q       <= '0;
      fail_seen_q  <= 1'b0;
      first_fail_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (clear) begin
      // IW is deliberately left alone so the ALU input does not glitch.
      state_q      <= S_IDLE;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wait_cnt_q   <= '0;
      pass_q       <= '0;
      fail_q       <= '0;
      fail_seen_q  <= 1'b0;
      first_fail_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (load_fire) begin
            count_q <= count_q + CW'(1);
          end
          if (start) begin
            pass_q       <= '0;
            fail_q       <= '0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
            rd_ptr_q     <= '0;
            if (count_q != '0) begin
              state_q <= S_ISSUE;
              iw_q    <= buf_q[0];
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          state_q    <= S_WAIT;
          wait_cnt_q <= LAT_W'(ALU_LATENCY);
        end

        S_WAIT: begin
          if (wait_cnt_q == LAT_W'(1)) begin
            state_q <= S_CHECK;
          end else begin
            wait_cnt_q <= wait_cnt_q - LAT_W'(1);
          end
        end

        S_CHECK: begin
          if (check_en) begin
            if (mismatch) begin
              fail_q <= fail_q + CW'(1);
              if (!fail_seen_q) begin
                fail_seen_q  <= 1'b1;
                first_fail_q <= rd_ptr_q;
              end
            end else begin
              pass_q <= pass_q + CW'(1);
            end
          end
          if (last_entry) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            rd_ptr_q <= next_idx;
            iw_q     <= buf_q[next_idx];
            state_q  <= S_ISSUE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign IW             = iw_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass_count     = pass_q;
  assign fail_count     = fail_q;
  assign fail_seen      = fail_seen_q;
  assign first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_alu_issue_checker.sv
// Bench: two checkers (ALU_LATENCY 1 and 3) share all inputs, each driving
// its own behavioural ALU stub. Expected replay statistics are queued when a
// replay is started; a monitor pops and compares on each rising done.
module tb_alu_issue_checker;
  import alu_issue_checker_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int IXW   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, clear, load_valid, start, bad_sub;
  instruction_t load_inst;
  instruction_t iw1, iw3;
  logic [31:0]  res1, res3;
  logic         lr1, lr3, busy1, busy3, done1, done3, seen1, seen3;
  logic [CW-1:0]  pc1, fc1, pc3, fc3;
  logic [IXW-1:0] idx1, idx3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  typedef struct {
    int pass_n;
    int fail_n;
    int seen;
    int idx;
    int lat;
  } run_t;

  run_t q1[$];
  run_t q3[$];

  alu_issue_checker #(.DEPTH(DEPTH), .ALU_LATENCY(1)) dut1 (
    .clock(clk), .reset_n(reset_n), .clear(clear), .load_valid(load_valid),
    .load_inst(load_inst), .load_ready(lr1), .start(start), .IW(iw1),
    .result(res1), .busy(busy1), .done(done1), .pass_count(pc1),
    .fail_count(fc1), .fail_seen(seen1), .first_fail_idx(idx1));

  alu_issue_checker #(.DEPTH(DEPTH), .ALU_LATENCY(3)) dut3 (
    .clock(clk), .reset_n(reset_n), .clear(clear), .load_valid(load_valid),
    .load_inst(load_inst), .load_ready(lr3), .start(start), .IW(iw3),
    .result(res3), .busy(busy3), .done(done3), .pass_count(pc3),
    .fail_count(fc3), .fail_seen(seen3), .first_fail_idx(idx3));

  // ALU stub; bad_sub makes SUB return a+b.
  function automatic logic [31:0] stub_alu(input instruction_t i, input logic bs);
    logic [31:0] r;
    case (i.opcode)
      ADD:     r = i.a + i.b;
      SUB:     r = bs ? (i.a + i.b) : (i.a - i.b);
      MUL:     r = i.a * i.b;
      default: r = 32'hDEADBEEF;
    endcase
    return r;
  endfunction

  logic [31:0] p3 [3];
  always @(posedge clk) begin
    res1  <= stub_alu(iw1, bad_sub);
    p3[0] <= stub_alu(iw3, bad_sub);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign res3 = p3[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_run(input string tag, input run_t e, input logic [CW-1:0] pc,
                           input logic [CW-1:0] fc, input logic seen, input logic [IXW-1:0] idx);
    chk({tag, " pass_count"}, pc, e.pass_n);
    chk({tag, " fail_count"}, fc, e.fail_n);
    chk({tag, " fail_seen"}, seen, e.seen);
    chk({tag, " first_fail_idx"}, idx, e.idx);
    chk({tag, " done latency"}, cyc - start_cyc, e.lat);
  endtask

  // Monitor: score each replay when done rises.
  logic done1_prev = 1'b0;
  logic done3_prev = 1'b0;
  always @(negedge clk) begin
    if (done1 && !done1_prev) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL L1 unexpected done: got done=1 expected no replay");
      end else begin
        run_t e;
        e = q1.pop_front();
        check_run("L1", e, pc1, fc1, seen1, idx1);
      end
    end
    if (done3 && !done3_prev) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL L3 unexpected done: got done=1 expected no replay");
      end else begin
        run_t e;
        e = q3.pop_front();
        check_run("L3", e, pc3, fc3, seen3, idx3);
      end
    end
    done1_prev = done1;
    done3_prev = done3;
  end

  task automatic expect_run(input int p, input int f, input int s, input int ix, input int n);
    run_t e;
    e.pass_n = p; e.fail_n = f; e.seen = s; e.idx = ix;
    e.lat = n * 3 + 1;
    q1.push_back(e);
    e.lat = n * 5 + 1;
    q3.push_back(e);
  endtask

  task automatic load_entry(input opcode_t op, input logic [31:0] ia, input logic [31:0] ib,
                            input logic exp_ready);
    load_inst  = '{opcode: op, a: ia, b: ib};
    load_valid = 1'b1;
    chk("load_ready L1", lr1, exp_ready);
    chk("load_ready L3", lr3, exp_ready);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic do_start();
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(done1 && done3) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!(done1 && done3)) begin
      checks++; errors++;
      $display("FAIL wait_done timeout: got done1=%0b done3=%0b expected both 1", done1, done3);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " IW L1"}, iw1, 66'h0);
    chk({tag, " IW L3"}, iw3, 66'h0);
    chk({tag, " load_ready L1"}, lr1, 1'b1);
    chk({tag, " load_ready L3"}, lr3, 1'b1);
    chk({tag, " busy L1"}, busy1, 1'b0);
    chk({tag, " busy L3"}, busy3, 1'b0);
    chk({tag, " done L1"}, done1, 1'b0);
    chk({tag, " done L3"}, done3, 1'b0);
    chk({tag, " pass L1"}, pc1, 0);
    chk({tag, " pass L3"}, pc3, 0);
    chk({tag, " fail L1"}, fc1, 0);
    chk({tag, " fail L3"}, fc3, 0);
    chk({tag, " seen L1"}, seen1, 1'b0);
    chk({tag, " seen L3"}, seen3, 1'b0);
    chk({tag, " idx L1"}, idx1, 0);
    chk({tag, " idx L3"}, idx3, 0);
  endtask

  task automatic load_basic();
    load_entry(ADD, 32'd10, 32'd15, 1'b1);
    load_entry(SUB, 32'd20, 32'd5, 1'b1);
    load_entry(MUL, 32'd3, 32'd7, 1'b1);
  endtask

  initial begin
    instruction_t last_iw;
    reset_n = 1'b0; clear = 1'b0; load_valid = 1'b0; start = 1'b0;
    load_inst = '0; bad_sub = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Basic program: 25, 15, 21 all pass.
    load_basic();
    expect_run(3, 0, 0, 0, 3);
    do_start();
    wait_done();
    last_iw = '{opcode: MUL, a: 32'd3, b: 32'd7};
    chk("IW holds last L1", iw1, last_iw);
    chk("IW holds last L3", iw3, last_iw);

    // Rerun from DONE with a broken SUB: entry 1 fails.
    bad_sub = 1'b1;
    expect_run(2, 1, 1, 1, 3);
    do_start();
    wait_done();
    bad_sub = 1'b0;

    // Wrap-around arithmetic behind a leading NOP.
    do_clear();
    chk("clear done L1", done1, 1'b0);
    chk("clear load_ready L1", lr1, 1'b1);
    chk("clear pass L1", pc1, 0);
    load_entry(NOP, 32'd5, 32'd5, 1'b1);
    load_entry(ADD, 32'hFFFF_FFFF, 32'd2, 1'b1);
    load_entry(SUB, 32'd0, 32'd1, 1'b1);
    load_entry(MUL, 32'h0001_0000, 32'h0001_0000, 1'b1);
    expect_run(3, 0, 0, 0, 4);
    do_start();
    wait_done();
    bad_sub = 1'b1;
    expect_run(2, 1, 1, 2, 4);
    do_start();
    wait_done();
    bad_sub = 1'b0;

    // Fill to DEPTH, 9th entry refused; start while busy ignored.
    do_clear();
    for (int i = 0; i < 7; i++) load_entry(ADD, i, i + 1, 1'b1);
    load_entry(NOP, 32'd1, 32'd2, 1'b1);
    load_entry(ADD, 32'd100, 32'd1, 1'b0);
    expect_run(7, 0, 0, 0, 8);
    do_start();
    repeat (3) @(negedge clk);
    chk("busy mid-run L1", busy1, 1'b1);
    chk("load_ready busy L1", lr1, 1'b0);
    chk("load_ready busy L3", lr3, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Empty buffer: DONE on the next edge with zero counts.
    do_clear();
    expect_run(0, 0, 0, 0, 0);
    do_start();
    wait_done();

    // clear while the L1 checker waits on its second entry.
    do_clear();
    load_entry(ADD, 32'd1, 32'd1, 1'b1);
    load_entry(ADD, 32'd2, 32'd2, 1'b1);
    do_start();
    repeat (4) @(negedge clk);
    chk("pre-clear pass L1", pc1, 1);
    chk("pre-clear busy L1", busy1, 1'b1);
    do_clear();
    chk("post-clear busy L1", busy1, 1'b0);
    chk("post-clear busy L3", busy3, 1'b0);
    chk("post-clear pass L1", pc1, 0);
    chk("post-clear done L1", done1, 1'b0);
    chk("post-clear load_ready L1", lr1, 1'b1);

    // Asynchronous reset while both checkers are in WAIT.
    load_entry(ADD, 32'd7, 32'd8, 1'b1);
    load_entry(ADD, 32'd1, 32'd2, 1'b1);
    do_start();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_vals("async reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Fresh program after reset, run twice.
    load_basic();
    expect_run(3, 0, 0, 0, 3);
    do_start();
    wait_done();
    expect_run(3, 0, 0, 0, 3);
    do_start();
    wait_done();

    repeat (5) @(negedge clk);
    chk("scoreboard drained L1", q1.size(), 0);
    chk("scoreboard drained L3", q3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_checker.md
# alu_issue_checker

Self-checking instruction issuer that drives `instruction_t` words into a clocked ALU instance (any of the ALU variants) and checks each returned `result` against an internal reference model. A small program buffer is loaded from the bench or a host, replayed on `start`, and pass/fail statistics are reported. It sits on the opposite side of the ALU instruction interface from the ALU, replacing hand-written stimulus/score sequences in ALU testbenches.

## Interface
Parameters:
- `DEPTH`, 8: program buffer entries (2..255).
- `ALU_LATENCY`, 1: clock edges from `IW` change to valid `result` (1..15).

Ports (`CW` = $clog2(DEPTH+1), `IW_` = $clog2(DEPTH)):
- `clock`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  empty buffer, return to IDLE (synchronous).
- `load_valid`  in  1  program entry offered.
- `load_inst`  in  instruction_t  entry to store.
- `load_ready`  out  1  entry accepted when `load_valid && load_ready`.
- `start`  in  1  begin replay of loaded program.
- `IW`  out  instruction_t  registered instruction to ALU.
- `result`  in  32  ALU result.
- `busy`  out  1  replay in progress.
- `done`  out  1  replay finished; level until `start`/`clear`.
- `pass_count`, `fail_count`  out  CW  checked entries.
- `fail_seen`  out  1  at least one mismatch.
- `first_fail_idx`  out  IW_  index of first mismatch.

## Operation
- States: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE: `load_ready = (count < DEPTH)`; accepted entry written at `wr_ptr`, `count++`. `start` in IDLE: clear counters/flags, `rd_ptr=0`; go ISSUE if `count>0`, else DONE directly (all counts 0).
- ISSUE (1 cycle): `IW <= buf[rd_ptr]` on entry edge; go WAIT, wait counter = ALU_LATENCY.
- WAIT (ALU_LATENCY cycles): `IW` held; go CHECK when counter expires.
- CHECK (1 cycle): compare `result` with expected; on edge leaving CHECK update counters. `rd_ptr == count-1` -> DONE, else `rd_ptr++`, ISSUE.
- Expected model (all mod 2^32): ADD `a+b`; SUB `a-b`; MUL low 32 bits of `a*b`; NOP not checked, no counter change.
- Mismatch: `fail_count++`; if `!fail_seen`, set `fail_seen`, `first_fail_idx = rd_ptr`.
- DONE: `done=1`, `IW` holds last instruction. `start` reruns the same buffer (counters cleared). Loading disabled outside IDLE (`load_ready=0`).
- `clear` any state: `count=0`, pointers 0, counters/flags 0, `busy=done=0`, IDLE; `IW` unchanged. `clear` wins over simultaneous `start`/`load_valid`.
- `start` while ISSUE/WAIT/CHECK ignored.

## Timing
- Reset values: `IW='0` (opcode ADD, a=b=0), `load_ready=1`, `busy=0`, `done=0`, counts 0, `fail_seen=0`, `first_fail_idx=0`; buffer contents undefined, `count=0`.
- Reset asserted mid-replay aborts immediately to reset values.
- Per entry: ALU_LATENCY+2 cycles; N entries complete N*(ALU_LATENCY+2) cycles after the edge sampling `start`, plus one edge into DONE.
- `busy` high in ISSUE/WAIT/CHECK only; `done` rises on the edge entering DONE.
- Load: one entry per cycle max; load at `count==DEPTH` refused (`load_ready=0`).

## Structure
- Shared package (with the ALU): `opcode_t` (2-bit enum ADD=0, SUB=1, MUL=2, NOP=3), `instruction_t` packed struct {opcode, a[31:0], b[31:0]}, plus new `alu_expected()` function used by both this block and benches.
- One sub-module: `alu_ref_model` (combinational expected-value computation, returns value and `check_en`).
- State enum local to the block.

## Test plan
- Load {ADD 10,15}, {SUB 20,5}, {MUL 3,7} against correct ALU; start -> `result` 25,15,21 checked, `pass_count=3`, `fail_count=0`, `done` after 3*(ALU_LATENCY+2)+1 cycles.
- ALU stub forcing SUB wrong (returns `a+b`): same program -> `fail_count=1`, `fail_seen=1`, `first_fail_idx=1`.
- Wrap: ADD 0xFFFFFFFF,2 -> expected 1; SUB 0,1 -> 0xFFFFFFFF; MUL 0x10000,0x10000 -> 0; all pass.
- Fill DEPTH=8 entries, offer 9th -> `load_ready=0`, entry dropped; NOP entry leaves counters unchanged.
- `start` with empty buffer -> DONE next edge, counts 0; `clear` during WAIT -> IDLE, `busy=0`, counts 0.
- Assert `reset_n` low mid-WAIT -> all outputs at reset values asynchronously; `ALU_LATENCY=3` rerun passes.
